// File: rtl/core_lsu.sv
// core_lsu: load/store unit between execute and the data-memory bus.
// Computes EA, byte strobes and lane-shifted store data, runs a REQ/GNT then
// RVALID handshake, and returns a sign/zero-extended load result with status.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined = misaligned accesses
// complete with MISALIGN and no bus request; undefined = EA is force-aligned).
module core_lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic                CLK,
    input  logic                NRST,
    input  logic                START,
    input  logic [6:0]          OPCODE,
    input  logic [2:0]          FUNCT3,
    input  logic [XLEN-1:0]     IMM,
    input  logic [XLEN-1:0]     REG_RDATA1,
    input  logic [XLEN-1:0]     REG_RDATA2,
    output logic                BUSY,
    output logic                DONE,
    output logic [XLEN-1:0]     LOAD_DATA,
    output logic                MISALIGN,
    output logic                ILLEGAL,
    output logic                BUS_ERR,
    output logic                DMEM_REQ,
    input  logic                DMEM_GNT,
    output logic                DMEM_WE,
    output logic [XLEN-1:0]     DMEM_ADDR,
    output logic [XLEN/8-1:0]   DMEM_STRB,
    output logic [XLEN-1:0]     DMEM_WDATA,
    input  logic                DMEM_RVALID,
    input  logic [XLEN-1:0]     DMEM_RDATA,
    input  logic                DMEM_ERR
);

    localparam int unsigned STRBW = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(STRBW);

    localparam logic [6:0] OPCODE_I_LOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_S      = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              misalign_q, misalign_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [STRBW-1:0]  strb_q, strb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;

    logic              is_load_c;
    logic              is_store_c;
    logic              illegal_c;
    logic [1:0]        size_c;
    logic [2:0]        align_mask_c;
    logic [XLEN-1:0]   ea_c;
    logic [XLEN-1:0]   ea_al_c;
    logic [OFFW-1:0]   off_c;
    logic [STRBW-1:0]  byte_en_c;
    logic [STRBW-1:0]  strb_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   rshift_c;
    logic [XLEN-1:0]   ext_c;
    logic              sign_c;

    // Decode: legality, effective address, natural alignment, strobes, store lanes
    always_comb begin
        is_load_c  = (OPCODE == OPCODE_I_LOAD);
        is_store_c = (OPCODE == OPCODE_S);
        size_c     = FUNCT3[1:0];

        illegal_c = 1'b0;
        if (!(is_load_c || is_store_c)) begin
            illegal_c = 1'b1;
        end else if (is_load_c && (FUNCT3 == 3'b111)) begin
            illegal_c = 1'b1;
        end else if (is_store_c && FUNCT3[2]) begin
            illegal_c = 1'b1;
        end else if ((XLEN == 32) && ((FUNCT3 == 3'b011) || (FUNCT3 == 3'b110))) begin
            illegal_c = 1'b1;
        end

        case (size_c)
            2'd0:    align_mask_c = 3'b000;
            2'd1:    align_mask_c = 3'b001;
            2'd2:    align_mask_c = 3'b011;
            default: align_mask_c = 3'b111;
        endcase

        ea_c    = REG_RDATA1 + IMM;
        ea_al_c = ea_c & ~XLEN'(align_mask_c);
        off_c   = ea_al_c[OFFW-1:0];

        for (int i = 0; i < int'(STRBW); i++) begin
            byte_en_c[i] = (i < (1 << size_c));
        end
        strb_c  = byte_en_c << off_c;
        wdata_c = REG_RDATA2 << {off_c, 3'b000};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_c;
    assign misalign_c = |(ea_c[2:0] & align_mask_c);
`endif

    // Load steering: shift the addressed lane down, then sign/zero-extend
    always_comb begin
        rshift_c = DMEM_RDATA >> {off_q, 3'b000};
        case (size_q)
            2'd0:    sign_c = rshift_c[7];
            2'd1:    sign_c = rshift_c[15];
            2'd2:    sign_c = rshift_c[31];
            default: sign_c = rshift_c[XLEN-1];
        endcase
        sign_c = sign_c & sext_q;
        for (int i = 0; i < int'(XLEN); i++) begin
            ext_c[i] = (i < (8 << size_q)) ? rshift_c[i] : sign_c;
        end
    end

    // Bus FSM next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_data_d = load_data_q;
        misalign_d  = misalign_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        sext_d      = sext_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (illegal_c) begin
                        state_d     = S_FIN;
                        done_d      = 1'b1;
                        illegal_d   = 1'b1;
                        misalign_d  = 1'b0;
                        bus_err_d   = 1'b0;
                        load_data_d = '0;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misalign_c) begin
                        state_d     = S_FIN;
                        done_d      = 1'b1;
                        illegal_d   = 1'b0;
                        misalign_d  = 1'b1;
                        bus_err_d   = 1'b0;
                        load_data_d = '0;
                    end
`endif
                    else begin
                        state_d = S_REQ;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_store_c;
                        addr_d  = {ea_al_c[XLEN-1:OFFW], OFFW'(0)};
                        strb_d  = strb_c;
                        wdata_d = wdata_c;
                        off_d   = off_c;
                        size_d  = size_c;
                        sext_d  = is_load_c & ~FUNCT3[2];
                    end
                end
            end
            S_REQ: begin
                if (DMEM_GNT) begin
                    state_d = S_RESP;
                    req_d   = 1'b0;
                end
            end
            S_RESP: begin
                if (DMEM_RVALID) begin
                    state_d     = S_FIN;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    bus_err_d   = DMEM_ERR;
                    illegal_d   = 1'b0;
                    misalign_d  = 1'b0;
                    load_data_d = (DMEM_ERR || we_q) ? '0 : ext_c;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding transaction
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            strb_q      <= '0;
            wdata_q     <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            illegal_q   <= illegal_d;
            bus_err_q   <= bus_err_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign LOAD_DATA  = load_data_q;
    assign MISALIGN   = misalign_q;
    assign ILLEGAL    = illegal_q;
    assign BUS_ERR    = bus_err_q;
    assign DMEM_REQ   = req_q;
    assign DMEM_WE    = we_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_STRB  = strb_q;
    assign DMEM_WDATA = wdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: one XLEN=32 and one XLEN=64 instance.
module tb_core_lsu;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // XLEN=32 instance signals
    logic        n_start, n_busy, n_done, n_mis, n_ill, n_berr, n_req, n_gnt, n_we;
    logic        n_rvalid, n_err;
    logic [6:0]  n_op;
    logic [2:0]  n_f3;
    logic [31:0] n_imm, n_rs1, n_rs2, n_load, n_addr, n_wdata, n_rdata;
    logic [3:0]  n_strb;

    // XLEN=64 instance signals
    logic        w_start, w_busy, w_done, w_mis, w_ill, w_berr, w_req, w_gnt, w_we;
    logic        w_rvalid, w_err;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [63:0] w_imm, w_rs1, w_rs2, w_load, w_addr, w_wdata, w_rdata;
    logic [7:0]  w_strb;

    core_lsu #(.XLEN(32)) u_n (
        .CLK(clk), .NRST(nrst), .START(n_start), .OPCODE(n_op), .FUNCT3(n_f3),
        .IMM(n_imm), .REG_RDATA1(n_rs1), .REG_RDATA2(n_rs2),
        .BUSY(n_busy), .DONE(n_done), .LOAD_DATA(n_load),
        .MISALIGN(n_mis), .ILLEGAL(n_ill), .BUS_ERR(n_berr),
        .DMEM_REQ(n_req), .DMEM_GNT(n_gnt), .DMEM_WE(n_we), .DMEM_ADDR(n_addr),
        .DMEM_STRB(n_strb), .DMEM_WDATA(n_wdata), .DMEM_RVALID(n_rvalid),
        .DMEM_RDATA(n_rdata), .DMEM_ERR(n_err)
    );

    core_lsu #(.XLEN(64)) u_w (
        .CLK(clk), .NRST(nrst), .START(w_start), .OPCODE(w_op), .FUNCT3(w_f3),
        .IMM(w_imm), .REG_RDATA1(w_rs1), .REG_RDATA2(w_rs2),
        .BUSY(w_busy), .DONE(w_done), .LOAD_DATA(w_load),
        .MISALIGN(w_mis), .ILLEGAL(w_ill), .BUS_ERR(w_berr),
        .DMEM_REQ(w_req), .DMEM_GNT(w_gnt), .DMEM_WE(w_we), .DMEM_ADDR(w_addr),
        .DMEM_STRB(w_strb), .DMEM_WDATA(w_wdata), .DMEM_RVALID(w_rvalid),
        .DMEM_RDATA(w_rdata), .DMEM_ERR(w_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Minimum-latency 32-bit transaction: GNT in cycle 1, RVALID in cycle 2, DONE in cycle 3
    task automatic txn32(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_load);
        @(negedge clk);
        n_op = op; n_f3 = f3; n_rs1 = rs1; n_imm = imm; n_rs2 = rs2; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        chk({tag, ".req"},  64'(n_req),  64'd1);
        chk({tag, ".busy"}, 64'(n_busy), 64'd1);
        chk({tag, ".we"},   64'(n_we),   64'(op == OP_ST));
        chk({tag, ".addr"}, 64'(n_addr), 64'(e_addr));
        chk({tag, ".strb"}, 64'(n_strb), 64'(e_strb));
        if (op == OP_ST) chk({tag, ".wdata"}, 64'(n_wdata), 64'(e_wdata));
        n_gnt = 1'b1;
        @(negedge clk);
        n_gnt = 1'b0;
        chk({tag, ".req_drop"}, 64'(n_req),  64'd0);
        chk({tag, ".no_done"},  64'(n_done), 64'd0);
        n_rvalid = 1'b1; n_rdata = rdata; n_err = 1'b0;
        @(negedge clk);
        n_rvalid = 1'b0; n_rdata = 32'h0;
        chk({tag, ".done"}, 64'(n_done), 64'd1);
        chk({tag, ".busy_fall"}, 64'(n_busy), 64'd0);
        chk({tag, ".load"}, 64'(n_load), 64'(e_load));
        chk({tag, ".status"}, {61'd0, n_mis, n_ill, n_berr}, 64'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(n_done), 64'd0);
    endtask

    // Minimum-latency 64-bit transaction
    task automatic txn64(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] rs1, input logic [63:0] imm, input logic [63:0] rs2,
                         input logic [63:0] rdata, input logic [63:0] e_addr,
                         input logic [7:0] e_strb, input logic [63:0] e_wdata,
                         input logic [63:0] e_load);
        @(negedge clk);
        w_op = op; w_f3 = f3; w_rs1 = rs1; w_imm = imm; w_rs2 = rs2; w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        chk({tag, ".req"},  64'(w_req),  64'd1);
        chk({tag, ".addr"}, w_addr, e_addr);
        chk({tag, ".strb"}, 64'(w_strb), 64'(e_strb));
        if (op == OP_ST) chk({tag, ".wdata"}, w_wdata, e_wdata);
        w_gnt = 1'b1;
        @(negedge clk);
        w_gnt = 1'b0;
        w_rvalid = 1'b1; w_rdata = rdata; w_err = 1'b0;
        @(negedge clk);
        w_rvalid = 1'b0; w_rdata = 64'h0;
        chk({tag, ".done"}, 64'(w_done), 64'd1);
        chk({tag, ".load"}, w_load, e_load);
        @(negedge clk);
    endtask

    initial begin
        nrst = 1'b0;
        n_start = 1'b0; n_op = '0; n_f3 = '0; n_imm = '0; n_rs1 = '0; n_rs2 = '0;
        n_gnt = 1'b0; n_rvalid = 1'b0; n_rdata = '0; n_err = 1'b0;
        w_start = 1'b0; w_op = '0; w_f3 = '0; w_imm = '0; w_rs1 = '0; w_rs2 = '0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_err = 1'b0;

        // Reset values
        #2;
        chk("rst.busy_done_req_we", {60'd0, n_busy, n_done, n_req, n_we}, 64'd0);
        chk("rst.status", {61'd0, n_mis, n_ill, n_berr}, 64'd0);
        chk("rst.addr", 64'(n_addr), 64'd0);
        chk("rst.strb", 64'(n_strb), 64'd0);
        chk("rst.wdata", 64'(n_wdata), 64'd0);
        chk("rst.load", 64'(n_load), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Store byte into the top lane
        txn32("sb", OP_ST, 3'b000, 32'h0000_1000, 32'd3, 32'h1234_56AB, 32'h0,
              32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0);
        // Signed and unsigned byte loads from lane 3
        txn32("lb", OP_LD, 3'b000, 32'h0000_2000, 32'd3, 32'h0, 32'h80FF_0000,
              32'h0000_2000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        txn32("lbu", OP_LD, 3'b100, 32'h0000_2000, 32'd3, 32'h0, 32'h80FF_0000,
              32'h0000_2000, 4'b1000, 32'h0, 32'h0000_0080);

        // Illegal: LD-size load on XLEN=32
        @(negedge clk);
        n_op = OP_LD; n_f3 = 3'b011; n_rs1 = 32'h100; n_imm = 32'h0; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        chk("ill_ld.done", 64'(n_done), 64'd1);
        chk("ill_ld.illegal", 64'(n_ill), 64'd1);
        chk("ill_ld.req", 64'(n_req), 64'd0);
        chk("ill_ld.busy", 64'(n_busy), 64'd0);
        @(negedge clk);
        chk("ill_ld.req_after", 64'(n_req), 64'd0);
        chk("ill_ld.hold", 64'(n_ill), 64'd1);

        // Illegal: non-memory opcode
        n_op = OP_ALU; n_f3 = 3'b000; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        chk("ill_op.done_ill", {62'd0, n_done, n_ill}, 64'd3);
        chk("ill_op.req", 64'(n_req), 64'd0);

        // Halfword sign extension and wrapping EA (0x3000 + -4)
        txn32("lh", OP_LD, 3'b001, 32'h0000_2000, 32'd2, 32'h0, 32'h8001_1234,
              32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
        txn32("lw_wrap", OP_LD, 3'b010, 32'h0000_3000, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF,
              32'h0000_2FFC, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        txn32("sh", OP_ST, 3'b001, 32'h0000_0010, 32'd2, 32'h0000_BEEF, 32'h0,
              32'h0000_0010, 4'b1100, 32'hBEEF_0000, 32'h0);

        // Misaligned halfword at 0x1001
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        n_op = OP_LD; n_f3 = 3'b001; n_rs1 = 32'h1000; n_imm = 32'd1; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        chk("mis.done", 64'(n_done), 64'd1);
        chk("mis.misalign", 64'(n_mis), 64'd1);
        chk("mis.req", 64'(n_req), 64'd0);
        @(negedge clk);
        chk("mis.req_after", 64'(n_req), 64'd0);
`else
        txn32("lh_mis", OP_LD, 3'b001, 32'h0000_1000, 32'd1, 32'h0, 32'h1234_8765,
              32'h0000_1000, 4'b0011, 32'h0, 32'hFFFF_8765);
`endif

        // Stalled grant, ignored START while busy, delayed response with bus error
        @(negedge clk);
        n_op = OP_LD; n_f3 = 3'b010; n_rs1 = 32'h4000; n_imm = 32'd8; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.req", i), 64'(n_req), 64'd1);
            chk($sformatf("stall%0d.addr", i), 64'(n_addr), 64'h4008);
            chk($sformatf("stall%0d.strb", i), 64'(n_strb), 64'hF);
            chk($sformatf("stall%0d.busy", i), 64'(n_busy), 64'd1);
            n_start = (i == 1);
            if (i == 1) begin
                n_op = OP_ST; n_f3 = 3'b000; n_rs1 = 32'h5000; n_imm = 32'd1;
            end
            @(negedge clk);
        end
        n_start = 1'b0;
        chk("stall.addr_final", 64'(n_addr), 64'h4008);
        chk("stall.we", 64'(n_we), 64'd0);
        n_gnt = 1'b1;
        @(negedge clk);
        n_gnt = 1'b0;
        chk("stall.req_drop", 64'(n_req), 64'd0);
        @(negedge clk);
        chk("stall.wait_done", 64'(n_done), 64'd0);
        chk("stall.wait_busy", 64'(n_busy), 64'd1);
        n_rvalid = 1'b1; n_err = 1'b1; n_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_rvalid = 1'b0; n_err = 1'b0; n_rdata = 32'h0;
        chk("berr.done", 64'(n_done), 64'd1);
        chk("berr.bus_err", 64'(n_berr), 64'd1);
        chk("berr.load", 64'(n_load), 64'd0);
        @(negedge clk);
        chk("berr.idle", {62'd0, n_req, n_busy}, 64'd0);
        chk("berr.hold", 64'(n_berr), 64'd1);

        // Reset while waiting for the response
        n_op = OP_LD; n_f3 = 3'b010; n_rs1 = 32'h6000; n_imm = 32'd4; n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        n_gnt = 1'b1;
        @(negedge clk);
        n_gnt = 1'b0;
        chk("rresp.in_resp_busy", 64'(n_busy), 64'd1);
        #1 nrst = 1'b0;
        #1;
        chk("rresp.busy_done_req_we", {60'd0, n_busy, n_done, n_req, n_we}, 64'd0);
        chk("rresp.status", {61'd0, n_mis, n_ill, n_berr}, 64'd0);
        chk("rresp.addr", 64'(n_addr), 64'd0);
        chk("rresp.strb", 64'(n_strb), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        n_rvalid = 1'b1; n_rdata = 32'h5555_5555;
        @(negedge clk);
        n_rvalid = 1'b0;
        chk("rresp.no_done0", 64'(n_done), 64'd0);
        @(negedge clk);
        chk("rresp.no_done1", 64'(n_done), 64'd0);
        chk("rresp.load", 64'(n_load), 64'd0);

        // XLEN=64 accesses
        txn64("w_ld", OP_LD, 3'b011, 64'h0000_0001_0000_0000, 64'h8, 64'h0,
              64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0008, 8'hFF, 64'h0,
              64'h0123_4567_89AB_CDEF);
        txn64("w_lwu", OP_LD, 3'b110, 64'h2000, 64'h4, 64'h0,
              64'h8000_0001_DEAD_BEEF, 64'h2000, 8'hF0, 64'h0,
              64'h0000_0000_8000_0001);
        txn64("w_lw", OP_LD, 3'b010, 64'h2000, 64'h4, 64'h0,
              64'h8000_0001_DEAD_BEEF, 64'h2000, 8'hF0, 64'h0,
              64'hFFFF_FFFF_8000_0001);
        txn64("w_sd", OP_ST, 3'b011, 64'h3000, 64'h10, 64'h1122_3344_5566_7788,
              64'h0, 64'h3010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        txn64("w_sb", OP_ST, 3'b000, 64'h3000, 64'h5, 64'hAB,
              64'h0, 64'h3000, 8'h20, 64'h0000_AB00_0000_0000, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
